// File: rtl/note_pkg.sv
// Shared types and constants for the falling-note lane sequencer.
package note_pkg;

    localparam int NUM_LANES = 5;
    localparam int Y_W       = 10;
    localparam int TIME_W    = 16;

    localparam logic [Y_W-1:0] PARK_Y = '1;

    typedef enum logic [2:0] {
        LANE_GREEN  = 3'd0,
        LANE_RED    = 3'd1,
        LANE_YELLOW = 3'd2,
        LANE_BLUE   = 3'd3,
        LANE_ORANGE = 3'd4
    } lane_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [TIME_W-1:0]    frame_stamp;
        logic [NUM_LANES-1:0] lane_mask;
    } chart_entry_t;

endpackage

// File: rtl/lane_note_ctr.sv
// One falling-note lane: y position and live flag, advanced on accepted ticks.
// A spawn always restarts the lane at the top, even if a note is still falling.
module lane_note_ctr
    import note_pkg::*;
#(
    parameter int SPEED     = 2,
    parameter int DESPAWN_Y = 480
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           tick,
    input  logic           spawn,
    output logic [Y_W-1:0] y,
    output logic           active
);

    // One extra bit so the expiry compare cannot be fooled by wrap-around.
    logic [Y_W:0] y_sum;
    logic         expire;

    assign y_sum  = {1'b0, y} + (Y_W+1)'(SPEED);
    assign expire = (y_sum >= (Y_W+1)'(DESPAWN_Y));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            y      <= PARK_Y;
            active <= 1'b0;
        end else if (spawn) begin
            y      <= '0;
            active <= 1'b1;
        end else if (tick && active) begin
            if (expire) begin
                y      <= PARK_Y;
                active <= 1'b0;
            end else begin
                y      <= y_sum[Y_W-1:0];
            end
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Chart-driven note scheduler: fetches {frame_stamp, lane_mask} entries and spawns notes into the lanes.
// Optional build macro LOOP_CHART_EN: the end-of-chart marker rewinds to address 0 instead of draining.
module note_sequencer
    import note_pkg::*;
#(
    parameter int SPEED     = 2,
    parameter int DESPAWN_Y = 480,
    parameter int ADDR_W    = 8
) (
    input  logic                              Clk,
    input  logic                              Reset_n,
    input  logic                              start,
    input  logic                              pause,
    input  logic                              frame_tick,
    output logic                              chart_req,
    output logic [ADDR_W-1:0]                 chart_addr,
    input  logic                              chart_valid,
    input  logic [TIME_W+NUM_LANES-1:0]       chart_data,
    output logic [NUM_LANES-1:0][Y_W-1:0]     lane_y,
    output logic [NUM_LANES-1:0]              lane_active,
    output logic [TIME_W-1:0]                 frame_count,
    output logic                              done
);

    seq_state_t           state, state_nxt;
    chart_entry_t         entry;
    chart_entry_t         data_in;
    logic                 tick_acc;
    logic                 spawn_ok;
    logic [NUM_LANES-1:0] spawn_mask;
    logic                 take;
    logic                 restart;

    assign data_in    = chart_entry_t'(chart_data);
    assign tick_acc   = frame_tick && !pause && (state inside {FETCH, HOLD, DRAIN});
    // The stamp is compared against the count before this tick's increment.
    assign spawn_ok   = (state == HOLD) && tick_acc && (entry.frame_stamp <= frame_count);
    assign spawn_mask = spawn_ok ? entry.lane_mask : '0;
    assign done       = (state == DONE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        chart_req = 1'b0;
        take      = 1'b0;
        restart   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = FETCH;
                    restart   = 1'b1;
                end
            end
            FETCH: begin
                chart_req = 1'b1;
                if (chart_valid) begin
                    take = 1'b1;
                    if (data_in.lane_mask != '0) begin
                        state_nxt = HOLD;
                    end else begin
`ifdef LOOP_CHART_EN
                        restart   = 1'b1;
`else
                        state_nxt = DRAIN;
`endif
                    end
                end
            end
            HOLD: begin
                if (spawn_ok) begin
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                if (lane_active == '0) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Restart (new run or chart loop) takes priority over address advance and frame counting.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            chart_addr  <= '0;
            frame_count <= '0;
        end else if (restart) begin
            chart_addr  <= '0;
            frame_count <= '0;
        end else begin
            if (take) begin
                chart_addr <= chart_addr + ADDR_W'(1);
            end
            if (tick_acc && (frame_count != '1)) begin
                frame_count <= frame_count + TIME_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (take) begin
            entry <= data_in;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        lane_note_ctr #(
            .SPEED     (SPEED),
            .DESPAWN_Y (DESPAWN_Y)
        ) u_lane (
            .Clk     (Clk),
            .Reset_n (Reset_n),
            .tick    (tick_acc),
            .spawn   (spawn_mask[l]),
            .y       (lane_y[l]),
            .active  (lane_active[l])
        );
    end

endmodule
